// File: rtl/tft_pkg.sv
// ---------------------------------------------------------------------------
// tft_pkg
// Shared definitions for the TFT picture-move controller: default panel
// geometry, bus widths, RGB565 colour constants, the move-FSM state encoding
// and the axis direction encoding.
// ---------------------------------------------------------------------------
package tft_pkg;

  localparam int unsigned H_VALID_DEF = 480;
  localparam int unsigned V_VALID_DEF = 272;

  localparam int PIX_W  = 10;
  localparam int RGB_W  = 16;
  localparam int ADDR_W = 14;

  // Marker the timing generator drives outside the active area.
  localparam logic [PIX_W-1:0] PIX_NONE = 10'h3FF;

  localparam logic [RGB_W-1:0] RGB_WHITE = 16'hFFFF;
  localparam logic [RGB_W-1:0] RGB_BLACK = 16'h0000;
  localparam logic [RGB_W-1:0] RGB_RED   = 16'hF800;
  localparam logic [RGB_W-1:0] RGB_GREEN = 16'h07E0;
  localparam logic [RGB_W-1:0] RGB_BLUE  = 16'h001F;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } move_state_e;

endpackage

// File: rtl/tft_pic_move_ctrl_if.sv
// ---------------------------------------------------------------------------
// tft_pic_move_ctrl_if
// Pixel/ROM/status bundle between the TFT timing side and the picture-move
// controller.
//   pix_x, pix_y : current active pixel (PIX_NONE outside the active area)
//   run_en       : animate (1) / freeze (0)
//   rom_addr     : picture ROM word address from the controller
//   rom_data     : picture ROM data, one cycle after rom_addr
//   pix_data     : RGB565 pixel to the panel controller
//   pic_x0/pic_y0: current picture top-left corner
//   busy         : controller is animating
// master = timing generator / ROM side, slave = controller.
// ---------------------------------------------------------------------------
interface tft_pic_move_ctrl_if;
  import tft_pkg::*;

  logic [PIX_W-1:0]  pix_x;
  logic [PIX_W-1:0]  pix_y;
  logic              run_en;
  logic [RGB_W-1:0]  rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [RGB_W-1:0]  pix_data;
  logic [PIX_W-1:0]  pic_x0;
  logic [PIX_W-1:0]  pic_y0;
  logic              busy;

  modport master (
    output pix_x, pix_y, run_en, rom_data,
    input  rom_addr, pix_data, pic_x0, pic_y0, busy
  );

  modport slave (
    input  pix_x, pix_y, run_en, rom_data,
    output rom_addr, pix_data, pic_x0, pic_y0, busy
  );

endinterface

// File: rtl/tft_axis_bounce.sv
// ---------------------------------------------------------------------------
// tft_axis_bounce
// One axis of the bouncing picture: holds the position and direction and
// moves by STEP on each upd_i pulse, clamping and reversing at 0 and MAX.
//   tft_clk   : pixel clock
//   sys_rst_n : synchronous active-low reset (position 0, moving +)
//   upd_i     : one-cycle move request
//   pos_o     : current position
// ---------------------------------------------------------------------------
module tft_axis_bounce
  import tft_pkg::*;
#(
  parameter int unsigned MAX  = 380,
  parameter int unsigned STEP = 2
) (
  input  logic             tft_clk,
  input  logic             sys_rst_n,
  input  logic             upd_i,
  output logic [PIX_W-1:0] pos_o
);

  localparam logic [PIX_W:0]   MAX_P  = (PIX_W+1)'(MAX);
  localparam logic [PIX_W:0]   STEP_W = (PIX_W+1)'(STEP);
  localparam logic [PIX_W-1:0] STEP_N = PIX_W'(STEP);

  logic [PIX_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [PIX_W:0]   pos_ext;
  logic [PIX_W:0]   pos_sum;

  // One spare bit so pos+STEP cannot wrap before the compare.
  assign pos_ext = {1'b0, pos_q};
  assign pos_sum = pos_ext + STEP_W;

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (upd_i) begin
      if (dir_q == DIR_POS) begin
        if (pos_sum >= MAX_P) begin
          pos_d = MAX_P[PIX_W-1:0];
          dir_d = DIR_NEG;
        end else begin
          pos_d = pos_sum[PIX_W-1:0];
        end
      end else begin
        if (pos_ext <= STEP_W) begin
          pos_d = '0;
          dir_d = DIR_POS;
        end else begin
          pos_d = pos_q - STEP_N;
        end
      end
    end
  end

  always_ff @(posedge tft_clk) begin
    if (!sys_rst_n) begin
      pos_q <= '0;
      dir_q <= DIR_POS;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/tft_pic_move_ctrl.sv
// ---------------------------------------------------------------------------
// tft_pic_move_ctrl
// Bounces a PIC_W x PIC_H picture around an H_VALID x V_VALID panel,
// moving once every FRAME_DIV frames, and muxes ROM pixels over BG_COLOR.
//   tft_clk   : pixel clock (only clock)
//   sys_rst_n : synchronous active-low reset
//   bus       : pixel/ROM/status bundle (slave side)
//
// state | meaning
// WAIT  | after reset, picture parked at (0,0) until the first frame end
// RUN   | animating, position moves every FRAME_DIV frames
// HOLD  | frozen, position kept
// ---------------------------------------------------------------------------
module tft_pic_move_ctrl
  import tft_pkg::*;
#(
  parameter int unsigned      H_VALID   = H_VALID_DEF,
  parameter int unsigned      V_VALID   = V_VALID_DEF,
  parameter int unsigned      PIC_W     = 100,
  parameter int unsigned      PIC_H     = 100,
  parameter int unsigned      STEP      = 2,
  parameter int unsigned      FRAME_DIV = 2,
  parameter logic [RGB_W-1:0] BG_COLOR  = RGB_WHITE
) (
  input  logic                tft_clk,
  input  logic                sys_rst_n,
  tft_pic_move_ctrl_if.slave  bus
);

  localparam int unsigned      X_MAX    = H_VALID - PIC_W;
  localparam int unsigned      Y_MAX    = V_VALID - PIC_H;
  localparam logic [7:0]       DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [PIX_W-1:0] X_LAST   = PIX_W'(H_VALID - 1);
  localparam logic [PIX_W-1:0] Y_LAST   = PIX_W'(V_VALID - 1);
  localparam logic [PIX_W:0]   PIC_W_E  = (PIX_W+1)'(PIC_W);
  localparam logic [PIX_W:0]   PIC_H_E  = (PIX_W+1)'(PIC_H);

  move_state_e       state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              upd_q, upd_d;
  logic              in_pic_q;
  logic              frame_end;
  logic [PIX_W-1:0]  x0, y0;
  logic              in_x, in_y, in_pic;
  logic [PIX_W-1:0]  dx, dy;

  assign frame_end = (bus.pix_x == X_LAST) && (bus.pix_y == Y_LAST);

  // Moves are requested here and applied by the axes one cycle later, so a
  // reset on that cycle drops the move.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    upd_d   = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        ST_WAIT: begin
          state_d = bus.run_en ? ST_RUN : ST_HOLD;
          cnt_d   = '0;
        end
        ST_RUN: begin
          if (!bus.run_en) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else if (cnt_q == DIV_LAST) begin
            cnt_d = '0;
            upd_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_HOLD: begin
          if (bus.run_en) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge tft_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_WAIT;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
      in_pic_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
      in_pic_q <= in_pic;
    end
  end

  tft_axis_bounce #(.MAX(X_MAX), .STEP(STEP)) u_axis_x (
    .tft_clk   (tft_clk),
    .sys_rst_n (sys_rst_n),
    .upd_i     (upd_q),
    .pos_o     (x0)
  );

  tft_axis_bounce #(.MAX(Y_MAX), .STEP(STEP)) u_axis_y (
    .tft_clk   (tft_clk),
    .sys_rst_n (sys_rst_n),
    .upd_i     (upd_q),
    .pos_o     (y0)
  );

  // 11-bit compares keep x0+PIC_W from wrapping.
  assign in_x = (bus.pix_x != PIX_NONE)
             && ({1'b0, bus.pix_x} >= {1'b0, x0})
             && ({1'b0, bus.pix_x} <  ({1'b0, x0} + PIC_W_E));
  assign in_y = (bus.pix_y != PIX_NONE)
             && ({1'b0, bus.pix_y} >= {1'b0, y0})
             && ({1'b0, bus.pix_y} <  ({1'b0, y0} + PIC_H_E));
  assign in_pic = in_x && in_y;

  assign dx = bus.pix_x - x0;
  assign dy = bus.pix_y - y0;

  assign bus.rom_addr = in_pic ? (ADDR_W'(dy) * ADDR_W'(PIC_W) + ADDR_W'(dx))
                               : '0;
  assign bus.pix_data = in_pic_q ? bus.rom_data : BG_COLOR;
  assign bus.pic_x0   = x0;
  assign bus.pic_y0   = y0;
  assign bus.busy     = (state_q == ST_RUN);

endmodule

// File: tb/tb_tft_pic_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tft_pic_move_ctrl
// Two controller instances: A with the default panel, B with a square panel
// (equal X/Y range, STEP=3, move every frame) so both axes hit their corner
// on the same update. Frames are compressed: the bench drives the last
// active pixel for one cycle whenever it wants a frame end.
// ---------------------------------------------------------------------------
module tb_tft_pic_move_ctrl;

  localparam int H_A = 480, V_A = 272, STEP_A = 2, DIV_A = 2;
  localparam int H_B = 272, V_B = 272, STEP_B = 3, DIV_B = 1;
  localparam int PW  = 100, PH = 100;
  localparam logic [15:0] BG_A = 16'hFFFF;
  localparam logic [15:0] BG_B = 16'h001F;

  localparam int M_WAIT = 0, M_RUN = 1, M_HOLD = 2;

  typedef struct {
    int st;
    int cnt;
    int x;
    int y;
    bit nx;
    bit ny;
  } mdl_t;

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    int         addr;
    bit         inp;
  } pix_vec_t;

  logic tft_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  mdl_t ma, mb;
  pix_vec_t tbl [10];

  always #5 tft_clk = ~tft_clk;

  tft_pic_move_ctrl_if a_if ();
  tft_pic_move_ctrl_if b_if ();

  tft_pic_move_ctrl #(
    .H_VALID(H_A), .V_VALID(V_A), .PIC_W(PW), .PIC_H(PH),
    .STEP(STEP_A), .FRAME_DIV(DIV_A), .BG_COLOR(BG_A)
  ) dut_a (
    .tft_clk(tft_clk), .sys_rst_n(sys_rst_n), .bus(a_if.slave)
  );

  tft_pic_move_ctrl #(
    .H_VALID(H_B), .V_VALID(V_B), .PIC_W(PW), .PIC_H(PH),
    .STEP(STEP_B), .FRAME_DIV(DIV_B), .BG_COLOR(BG_B)
  ) dut_b (
    .tft_clk(tft_clk), .sys_rst_n(sys_rst_n), .bus(b_if.slave)
  );

  function automatic logic [15:0] rom_fn(input logic [13:0] a);
    return {a[6:0], a[13:5]} ^ 16'hA5C3;
  endfunction

  // Synchronous picture ROM stand-ins.
  always @(posedge tft_clk) begin
    a_if.rom_data <= rom_fn(a_if.rom_addr);
    b_if.rom_data <= rom_fn(b_if.rom_addr);
  end

  task automatic tick();
    @(posedge tft_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Bounce: step towards the current direction; reaching or passing an end
  // pins to that end and reverses.
  task automatic bnc(input int p, input bit neg, input int mx, input int st,
                     output int np, output bit nneg);
    int t;
    t = neg ? p - st : p + st;
    np = t;
    nneg = neg;
    if (t >= mx) begin
      np = mx;
      nneg = 1'b1;
    end else if (t <= 0) begin
      np = 0;
      nneg = 1'b0;
    end
  endtask

  // Frame-level behaviour: what happens to the picture at one frame end.
  task automatic mdl_frame(input mdl_t m, input bit run, input int div,
                           input int xmax, input int ymax, input int st,
                           output mdl_t n);
    n = m;
    if (m.st == M_WAIT) begin
      n.st = run ? M_RUN : M_HOLD;
    end else if (m.st == M_HOLD) begin
      if (run) n.st = M_RUN;
    end else if (!run) begin
      n.st = M_HOLD;
      n.cnt = 0;
    end else begin
      n.cnt = (m.cnt + 1) % div;
      if (n.cnt == 0) begin
        bnc(m.x, m.nx, xmax, st, n.x, n.nx);
        bnc(m.y, m.ny, ymax, st, n.y, n.ny);
      end
    end
  endtask

  task automatic mdl_reset();
    ma = '{st: M_WAIT, cnt: 0, x: 0, y: 0, nx: 1'b0, ny: 1'b0};
    mb = ma;
  endtask

  task automatic idle_all();
    a_if.pix_x = 10'h3FF; a_if.pix_y = 10'h3FF;
    b_if.pix_x = 10'h3FF; b_if.pix_y = 10'h3FF;
  endtask

  task automatic chk_pos_a(input string tag);
    chk({tag, "_x0"}, int'(a_if.pic_x0), ma.x);
    chk({tag, "_y0"}, int'(a_if.pic_y0), ma.y);
    chk({tag, "_busy"}, int'(a_if.busy), (ma.st == M_RUN) ? 1 : 0);
  endtask

  // One compressed frame on A; run_en is inverted between frame ends so only
  // the sampled value at the frame end may matter.
  task automatic frame_a(input bit run);
    a_if.run_en = run;
    a_if.pix_x = 10'd479; a_if.pix_y = 10'd271;
    tick();
    mdl_frame(ma, run, DIV_A, H_A - PW, V_A - PH, STEP_A, ma);
    chk("a_busy_fe", int'(a_if.busy), (ma.st == M_RUN) ? 1 : 0);
    a_if.pix_x = 10'h3FF; a_if.pix_y = 10'h3FF;
    a_if.run_en = ~run;
    repeat (3) tick();
    chk_pos_a("a");
  endtask

  task automatic frame_b(input bit run);
    b_if.run_en = run;
    b_if.pix_x = 10'd271; b_if.pix_y = 10'd271;
    tick();
    mdl_frame(mb, run, DIV_B, H_B - PW, V_B - PH, STEP_B, mb);
    b_if.pix_x = 10'h3FF; b_if.pix_y = 10'h3FF;
    b_if.run_en = ~run;
    repeat (3) tick();
    chk("b_x0", int'(b_if.pic_x0), mb.x);
    chk("b_y0", int'(b_if.pic_y0), mb.y);
    chk("b_busy", int'(b_if.busy), (mb.st == M_RUN) ? 1 : 0);
  endtask

  task automatic pix_chk_a(input int px, input int py);
    bit inp;
    int ea;
    inp = (px != 1023) && (py != 1023) && (px >= ma.x) && (px < ma.x + PW)
          && (py >= ma.y) && (py < ma.y + PH);
    ea = inp ? ((py - ma.y) * PW + (px - ma.x)) % 16384 : 0;
    a_if.pix_x = 10'(px); a_if.pix_y = 10'(py);
    #1;
    chk("a_rom_addr", int'(a_if.rom_addr), ea);
    tick();
    chk("a_pix_data", int'(a_if.pix_data), inp ? int'(rom_fn(14'(ea))) : int'(BG_A));
  endtask

  task automatic pix_chk_b(input int px, input int py);
    bit inp;
    int ea;
    inp = (px != 1023) && (py != 1023) && (px >= mb.x) && (px < mb.x + PW)
          && (py >= mb.y) && (py < mb.y + PH);
    ea = inp ? ((py - mb.y) * PW + (px - mb.x)) % 16384 : 0;
    b_if.pix_x = 10'(px); b_if.pix_y = 10'(py);
    #1;
    chk("b_rom_addr", int'(b_if.rom_addr), ea);
    tick();
    chk("b_pix_data", int'(b_if.pix_data), inp ? int'(rom_fn(14'(ea))) : int'(BG_B));
  endtask

  // Random pixel, biased towards the picture, never the frame-end pixel.
  task automatic rnd_pix(input int cx, input int cy, input int h, input int v,
                         output int px, output int py);
    if ($urandom_range(0, 1) == 1) begin
      px = cx + int'($urandom_range(0, PW + 1)) - 1;
      py = cy + int'($urandom_range(0, PH + 1)) - 1;
    end else begin
      px = int'($urandom_range(0, h - 1));
      py = int'($urandom_range(0, v - 1));
    end
    if (px < 0) px = 0;
    if (py < 0) py = 0;
    if (px > h - 1) px = h - 1;
    if (py > v - 1) py = v - 1;
    if ($urandom_range(0, 15) == 0) px = 1023;
    if ($urandom_range(0, 15) == 0) py = 1023;
    if (px == h - 1 && py == v - 1) py = v - 2;
  endtask

  initial begin
    int px, py;
    bit run;

    // Picture parked at (10,10).
    tbl[0] = '{10'd10,  10'd10,  0,    1'b1};
    tbl[1] = '{10'd109, 10'd109, 9999, 1'b1};
    tbl[2] = '{10'd110, 10'd10,  0,    1'b0};
    tbl[3] = '{10'd9,   10'd10,  0,    1'b0};
    tbl[4] = '{10'd10,  10'd109, 9900, 1'b1};
    tbl[5] = '{10'd10,  10'd110, 0,    1'b0};
    tbl[6] = '{10'd50,  10'd60,  5040, 1'b1};
    tbl[7] = '{10'h3FF, 10'h3FF, 0,    1'b0};
    tbl[8] = '{10'h3FF, 10'd10,  0,    1'b0};
    tbl[9] = '{10'd109, 10'd10,  99,   1'b1};

    idle_all();
    a_if.run_en = 1'b0;
    b_if.run_en = 1'b0;
    mdl_reset();
    sys_rst_n = 1'b0;
    tick(); tick();
    chk("rst_x0", int'(a_if.pic_x0), 0);
    chk("rst_y0", int'(a_if.pic_y0), 0);
    chk("rst_busy", int'(a_if.busy), 0);
    chk("rst_pix", int'(a_if.pix_data), int'(BG_A));
    sys_rst_n = 1'b1;
    pix_chk_a(5, 3);
    pix_chk_a(100, 0);

    // First frame end enters RUN; two more frames give the first move.
    frame_a(1'b1);
    chk("first_busy", int'(a_if.busy), 1);
    frame_a(1'b1);
    frame_a(1'b1);
    chk("first_move_x", int'(a_if.pic_x0), 2);
    chk("first_move_y", int'(a_if.pic_y0), 2);
    repeat (8) frame_a(1'b1);
    chk("park_x", int'(a_if.pic_x0), 10);
    chk("park_y", int'(a_if.pic_y0), 10);

    // run_en dropped mid-frame takes effect only at the frame end.
    a_if.run_en = 1'b0;
    repeat (4) tick();
    chk("mid_busy", int'(a_if.busy), 1);
    frame_a(1'b0);
    chk("hold_busy", int'(a_if.busy), 0);
    chk("hold_x", int'(a_if.pic_x0), 10);
    frame_a(1'b0);
    chk("hold2_y", int'(a_if.pic_y0), 10);

    for (int i = 0; i < 10; i++) begin
      a_if.pix_x = tbl[i].px; a_if.pix_y = tbl[i].py;
      #1;
      chk("tbl_addr", int'(a_if.rom_addr), tbl[i].addr);
      tick();
      chk("tbl_data", int'(a_if.pix_data),
          tbl[i].inp ? int'(rom_fn(14'(tbl[i].addr))) : int'(BG_A));
    end
    a_if.pix_x = 10'h3FF; a_if.pix_y = 10'h3FF;

    // Long random run on A: covers both X and Y bounces.
    for (int f = 0; f < 1000; f++) begin
      run = ($urandom_range(0, 7) != 0);
      frame_a(run);
      if (f % 5 == 0) begin
        for (int k = 0; k < 4; k++) begin
          rnd_pix(ma.x, ma.y, H_A, V_A, px, py);
          pix_chk_a(px, py);
        end
        a_if.pix_x = 10'h3FF; a_if.pix_y = 10'h3FF;
      end
    end

    // B: both axes share a range, so the corner is hit with both flipping.
    for (int f = 0; f < 130; f++) begin
      frame_b(1'b1);
      if (f % 10 == 0) begin
        for (int k = 0; k < 3; k++) begin
          rnd_pix(mb.x, mb.y, H_B, V_B, px, py);
          pix_chk_b(px, py);
        end
        b_if.pix_x = 10'h3FF; b_if.pix_y = 10'h3FF;
      end
    end

    // Reset on the move cycle abandons the move.
    for (int k = 0; k < 4; k++) begin
      if (ma.st == M_RUN && ma.cnt == DIV_A - 1) break;
      frame_a(1'b1);
    end
    chk("pre_upd_state", (ma.st == M_RUN && ma.cnt == DIV_A - 1) ? 1 : 0, int'(a_if.busy));
    a_if.run_en = 1'b1;
    a_if.pix_x = 10'd479; a_if.pix_y = 10'd271;
    tick();
    a_if.pix_x = 10'h3FF; a_if.pix_y = 10'h3FF;
    sys_rst_n = 1'b0;
    tick();
    chk("upd_rst_x0", int'(a_if.pic_x0), 0);
    chk("upd_rst_y0", int'(a_if.pic_y0), 0);
    chk("upd_rst_busy", int'(a_if.busy), 0);
    chk("upd_rst_pix", int'(a_if.pix_data), int'(BG_A));
    sys_rst_n = 1'b1;
    mdl_reset();
    repeat (5) tick();
    chk("post_rst_wait_busy", int'(a_if.busy), 0);
    chk("post_rst_wait_x0", int'(a_if.pic_x0), 0);
    frame_a(1'b1);
    frame_a(1'b1);
    frame_a(1'b1);
    chk("restart_x", int'(a_if.pic_x0), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tft_pic_move_ctrl.md
TFT_PIC_MOVE_CTRL -- requirements
Module: tft_pic_move_ctrl

Interface
REQ-001 Parameter H_VALID, default 480, active pixels per line.
REQ-002 Parameter V_VALID, default 272, active lines per frame.
REQ-003 Parameter PIC_W, default 100, picture width in pixels.
REQ-004 Parameter PIC_H, default 100, picture height in lines.
REQ-005 Parameter STEP, default 2, pixels moved per axis per update; must be 1..PIC_W.
REQ-006 Parameter FRAME_DIV, default 2, frames per position update, 1..255.
REQ-007 Parameter BG_COLOR, default 16'hFFFF, RGB565 colour outside the picture.
REQ-008 tft_clk  in  1  9 MHz pixel clock; only clock; all logic on the rising edge.
REQ-009 sys_rst_n  in  1  Reset; synchronous, active-low.
REQ-010 pix_x  in  10  Current active column; 10'h3FF outside the active area.
REQ-011 pix_y  in  10  Current active line; 10'h3FF outside the active area.
REQ-012 run_en  in  1  1 = animate, 0 = freeze picture; level input.
REQ-013 rom_data  in  16  Picture ROM read data; valid 1 cycle after rom_addr.
REQ-014 rom_addr  out  14  Picture ROM word address.
REQ-015 pix_data  out  16  RGB565 pixel to tft_ctrl.
REQ-016 pic_x0  out  10  Current picture left column.
REQ-017 pic_y0  out  10  Current picture top line.
REQ-018 busy  out  1  1 while the FSM is in RUN.

Function
REQ-019 frame_end: single-cycle internal event when pix_x==H_VALID-1 and pix_y==V_VALID-1.
REQ-020 FSM states: WAIT (after reset), RUN, HOLD; transitions occur only on frame_end.
REQ-021 WAIT->RUN if run_en=1, else WAIT->HOLD; RUN->HOLD if run_en=0; HOLD->RUN if run_en=1; otherwise stay.
REQ-022 run_en is sampled only at frame_end; mid-frame changes have no effect until the next frame_end.
REQ-023 An 8-bit frame counter increments at each frame_end in RUN and wraps to 0 after FRAME_DIV-1; cleared on entry to HOLD.
REQ-024 Position updates on the cycle after a frame_end in RUN where the counter equals FRAME_DIV-1; never mid-frame.
REQ-025 X range 0..H_VALID-PIC_W (380); Y range 0..V_VALID-PIC_H (172).
REQ-026 Moving +: if x0+STEP >= X_MAX then x0=X_MAX and dir_x flips; else x0+=STEP. Moving -: if x0 <= STEP then x0=0 and dir_x flips; else x0-=STEP. Same rules for Y.
REQ-027 A corner hit flips both directions in the same update.
REQ-028 in_pic = (x0 <= pix_x < x0+PIC_W) and (y0 <= pix_y < y0+PIC_H); 10'h3FF coordinates are never in_pic.
REQ-029 rom_addr = (pix_y-y0)*PIC_W + (pix_x-x0), truncated to 14 bits, when in_pic; else 0. Combinational from pix_x, pix_y, x0, y0.
REQ-030 in_pic is registered once (in_pic_d).
REQ-031 pix_data = in_pic_d ? rom_data : BG_COLOR, so pix_data lags pix_x/pix_y by exactly 1 cycle.
REQ-032 Arithmetic is unsigned; comparisons use 11-bit intermediates so x0+PIC_W cannot overflow.

Reset
REQ-033 While sys_rst_n=0 at a clock edge: state=WAIT, x0=0, y0=0, dir_x=+, dir_y=+, frame counter=0, in_pic_d=0.
REQ-034 Resulting outputs: pic_x0=0, pic_y0=0, busy=0, pix_data=BG_COLOR; rom_addr follows REQ-029 with x0=y0=0.
REQ-035 Reset mid-frame or mid-update abandons the update; the picture restarts at (0,0) and waits for the next frame_end.

Structure
REQ-036 Shared package tft_pkg holds H_VALID/V_VALID defaults, the RGB565 colour constants and the FSM state encoding.
REQ-037 One sub-module, tft_axis_bounce, instanced twice (X and Y): holds position and direction and implements REQ-026.
REQ-038 The picture ROM is instanced by the parent, not inside this block.

Verification
REQ-039 Reset, run_en=1, first frame_end -> busy=1 next cycle; after 2 more frames pic_x0=2, pic_y0=2.
REQ-040 Force x0=378, dir_x=+, update -> x0=380, dir_x=-; next update -> x0=378.
REQ-041 x0=380, y0=172, both + -> both flip in one update; next update gives (378,170).
REQ-042 Toggle run_en mid-frame -> no state/position change until frame_end; then HOLD with position frozen and busy=0.
REQ-043 x0=10, y0=20, pix=(10,20) -> rom_addr=0; pix=(109,119) -> rom_addr=9999; pix=(110,20) -> BG_COLOR after 1 cycle.
REQ-044 Assert sys_rst_n=0 on the update cycle -> pic_x0=pic_y0=0, busy=0, pix_data=BG_COLOR.
